// File: rtl/sa_cmd_byte_encoder.sv
// sa_cmd_byte_encoder: turns one word command into strobed {uart_rw, uart_data} byte frames.
// Optional SA_CMD_CHECKSUM_EN appends an XOR checksum byte to payload frames.
module sa_cmd_byte_encoder #(
    parameter int         GAP_CYCLES    = 0,
    parameter logic [7:0] DATA_ADDR_MIN = 8'hFA
) (
    input  logic        Clock,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_data0,
    input  logic [15:0] cmd_data1,
    input  logic [15:0] cmd_data2,
    input  logic [15:0] cmd_data3,
    output logic        uart_rw,
    output logic [7:0]  uart_data,
    output logic        busy,
    output logic        frame_done
);
    localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, PAYLOAD = 3'd2, GAP = 3'd3, DONE = 3'd4;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    logic [2:0]  state, pend, after;
    logic [3:0]  gcnt;
    logic [7:0]  addr_r, pay_byte;
    logic [63:0] data_r;
    logic        has_pay, last;
`ifdef SA_CMD_CHECKSUM_EN
    logic [3:0] idx;
    logic [7:0] csum;
    always_comb begin
        csum = addr_r;
        for (int i = 0; i < 8; i++) csum = csum ^ data_r[i*8 +: 8];
    end
    // idx 8 is the trailing checksum byte
    assign pay_byte = idx[3] ? csum : data_r[{idx[2:0], 3'b000} +: 8];
    assign last     = idx == 4'd8;
`else
    logic [2:0] idx;
    assign pay_byte = data_r[{idx, 3'b000} +: 8];
    assign last     = idx == 3'd7;
`endif
    assign has_pay    = addr_r >= DATA_ADDR_MIN && addr_r <= 8'hFC;
    assign after      = state == ADDR ? (has_pay ? PAYLOAD : DONE) : (last ? DONE : PAYLOAD);
    assign cmd_ready  = state == IDLE;
    assign busy       = state == ADDR || state == PAYLOAD || state == GAP;
    assign frame_done = state == DONE;
    assign uart_rw    = state == ADDR || state == PAYLOAD;
    assign uart_data  = state == ADDR ? addr_r : state == PAYLOAD ? pay_byte : 8'h00;

    always_ff @(posedge Clock) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= IDLE;
            idx    <= '0;
            gcnt   <= '0;
            addr_r <= '0;
            data_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= cmd_valid ? ADDR : IDLE;
                    idx    <= '0;
                    addr_r <= cmd_valid ? cmd_addr : addr_r;
                    data_r <= cmd_valid ? {cmd_data3, cmd_data2, cmd_data1, cmd_data0} : data_r;
                end
                ADDR, PAYLOAD: begin
                    idx   <= state == PAYLOAD ? idx + 1'b1 : idx;
                    gcnt  <= '0;
                    pend  <= after;
                    state <= GAP_CYCLES > 0 ? GAP : after;
                end
                GAP: begin
                    gcnt  <= gcnt + 1'b1;
                    state <= gcnt == GAP_LAST ? pend : GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_cmd_byte_encoder.sv
// tb_sa_cmd_byte_encoder: directed plus random frames on GAP=0 and GAP=2 encoders.
// Expected per-cycle traces come from a byte-list model of the frame format.
module tb_sa_cmd_byte_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  valid = 2'b00;
    logic [7:0]  addr = 8'h00;
    logic [15:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic        rw[2], rdy[2], bz[2], fd[2];
    logic [7:0]  ud[2];
    int          checks = 0, failures = 0;

    sa_cmd_byte_encoder #(.GAP_CYCLES(0)) u0 (
        .Clock(clk), .rst(rst), .cmd_valid(valid[0]), .cmd_ready(rdy[0]), .cmd_addr(addr),
        .cmd_data0(d0), .cmd_data1(d1), .cmd_data2(d2), .cmd_data3(d3),
        .uart_rw(rw[0]), .uart_data(ud[0]), .busy(bz[0]), .frame_done(fd[0]));

    sa_cmd_byte_encoder #(.GAP_CYCLES(2)) u1 (
        .Clock(clk), .rst(rst), .cmd_valid(valid[1]), .cmd_ready(rdy[1]), .cmd_addr(addr),
        .cmd_data0(d0), .cmd_data1(d1), .cmd_data2(d2), .cmd_data3(d3),
        .uart_rw(rw[1]), .uart_data(ud[1]), .busy(bz[1]), .frame_done(fd[1]));

    // observed vector: {uart_rw, uart_data, busy, cmd_ready, frame_done}
    function automatic logic [11:0] obs(int s);
        return {rw[s], ud[s], bz[s], rdy[s], fd[s]};
    endfunction

    task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ncyc=0 checks the whole frame through the following idle cycle
    task automatic run_cmd(int s, logic [7:0] a, logic [63:0] ln, bit hold, int mode, int ncyc);
        logic [7:0]  b[$];
        logic [11:0] q[$];
        logic [7:0]  cs;
        int          g;
        g = s ? 2 : 0;
        b.push_back(a);
        if (a >= 8'hFA && a <= 8'hFC) begin
            for (int k = 0; k < 8; k++) b.push_back(ln[k*8 +: 8]);
`ifdef SA_CMD_CHECKSUM_EN
            cs = 8'h00;
            foreach (b[k]) cs = cs ^ b[k];
            b.push_back(cs);
`endif
        end
        foreach (b[k]) begin
            q.push_back({1'b1, b[k], 3'b100});
            repeat (g) q.push_back(12'h004);
        end
        q.push_back(12'h001);
        q.push_back(12'h002);
        if (ncyc == 0) ncyc = q.size();
        chk($sformatf("s%0d a%h idle", s, a), obs(s), 12'h002);
        addr = a;
        {d3, d2, d1, d0} = ln;
        valid[s] = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (!hold) valid[s] = 1'b0;
            if (mode > 0) {d3, d2, d1, d0} = {$urandom, $urandom};
            if (mode > 1) addr = 8'($urandom);
            chk($sformatf("s%0d a%h c%0d", s, a, i + 1), obs(s), q[i]);
        end
    endtask

    initial begin
        logic [7:0]  ra;
        logic [63:0] lanes;
        repeat (2) @(posedge clk);
        #1;
        chk("reset0", obs(0), 12'h002);
        chk("reset1", obs(1), 12'h002);
        rst = 1'b0;
        @(posedge clk); #1;
        run_cmd(0, 8'hFF, 64'h0, 0, 0, 0);
        run_cmd(0, 8'hFC, {16'hFFFF, 16'h0001, 16'hABCD, 16'h1234}, 0, 0, 0);
        run_cmd(1, 8'hFA, {16'hFFFF, 16'h0001, 16'hABCD, 16'h1234}, 0, 0, 0);
        run_cmd(1, 8'hFF, 64'h0, 0, 0, 0);
        run_cmd(0, 8'hFE, {$urandom, $urandom}, 1, 1, 0);
        run_cmd(0, 8'hFD, {$urandom, $urandom}, 1, 1, 0);
        valid = 2'b00;
        @(posedge clk); #1;
        run_cmd(0, 8'hFB, {16'h0708, 16'h0506, 16'h0304, 16'h0102}, 0, 2, 0);
        run_cmd(1, 8'hFB, {16'h0708, 16'h0506, 16'h0304, 16'h0102}, 0, 2, 0);
        run_cmd(0, 8'hF9, {$urandom, $urandom}, 0, 0, 0);
        run_cmd(1, 8'h10, {$urandom, $urandom}, 0, 0, 0);
        run_cmd(0, 8'hFB, {$urandom, $urandom}, 0, 0, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst", obs(0), 12'h002);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst c%0d", i), obs(0), 12'h002);
        end
        for (int n = 0; n < 24; n++) begin
            ra = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hF8 + 8'($urandom_range(0, 7));
            lanes = {$urandom, $urandom};
            run_cmd($urandom_range(0, 1), ra, lanes, 0, $urandom_range(0, 2), 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
